// File: rtl/apb4_rng_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb4_rng_fetch                                                |
// | Purpose  : APB4 master that seeds an RNG responder and prefetches random |
// |            words into a small FIFO for a valid/ready consumer.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module apb4_rng_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic                    seed_valid_i,
  input  logic [DATA_WIDTH-1:0]   seed_i,
  output logic                    seed_ready_o,
  output logic                    rnd_valid_o,
  output logic [DATA_WIDTH-1:0]   rnd_data_o,
  input  logic                    rnd_ready_i,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  output logic [2:0]              pprot_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SEED_ADDR = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] VAL_ADDR  = BASE_ADDR + ADDR_WIDTH'(8);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]            state_q,      state_d;
  logic                  psel_q,       psel_d;
  logic                  penable_q,    penable_d;
  logic                  pwrite_q,     pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,      paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,     pwdata_d;
  logic [STRB_W-1:0]     pstrb_q,      pstrb_d;
  logic                  seed_ready_q, seed_ready_d;
  logic                  err_q,        err_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;

  logic seed_req;
  logic rd_req;
  logic xfer_done;
  logic push;
  logic pop;

  // seed_valid_i is still high in the cycle seed_ready_o pulses; masking it
  // there keeps one request from launching a second write.
  assign seed_req  = seed_valid_i & ~seed_ready_q;
  assign rd_req    = enable_i & (count_q < DEPTH_C);
  assign xfer_done = (state_q == S_ACCESS) & pready_i;
  assign push      = xfer_done & ~pwrite_q & ~pslverr_i;
  assign pop       = rnd_ready_i & (count_q != '0);

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (seed_req || rd_req) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ registered outputs
  always_comb begin
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    seed_ready_d = 1'b0;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (seed_req) begin
          psel_d   = 1'b1;
          paddr_d  = SEED_ADDR;
          pwrite_d = 1'b1;
          pwdata_d = seed_i;
          pstrb_d  = '1;
        end else if (rd_req) begin
          psel_d   = 1'b1;
          paddr_d  = VAL_ADDR;
          pwrite_d = 1'b0;
          pwdata_d = '0;
          pstrb_d  = '0;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (pready_i) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          seed_ready_d = pwrite_q;
          err_d        = err_q | pslverr_i;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      seed_ready_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      seed_ready_q <= seed_ready_d;
      err_q        <= err_d;
    end
  end

  // -------------------------------------------------------------- prefetch FIFO
  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = prdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rnd_valid_o  = (count_q != '0);
  assign rnd_data_o   = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign seed_ready_o = seed_ready_q;
  assign err_o        = err_q;
  assign psel_o       = psel_q;
  assign penable_o    = penable_q;
  assign pwrite_o     = pwrite_q;
  assign paddr_o      = paddr_q;
  assign pwdata_o     = pwdata_q;
  assign pstrb_o      = pstrb_q;
  assign pprot_o      = 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_apb4_rng_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_apb4_rng_fetch                                             |
// | Purpose  : Directed bench for apb4_rng_fetch with a simple APB responder. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_apb4_rng_fetch;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        seed_valid_i = 1'b0;
  logic [31:0] seed_i = '0;
  logic        seed_ready_o;
  logic        rnd_valid_o;
  logic [31:0] rnd_data_o;
  logic        rnd_ready_i = 1'b0;
  logic        err_o;
  logic [31:0] paddr_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [2:0]  pprot_o;
  logic        pready_i = 1'b0;
  logic [31:0] prdata_i = '0;
  logic        pslverr_i = 1'b0;

  int          n_cmp = 0;
  int          n_fail = 0;

  // responder state
  logic [31:0] resp_val = 32'hA5A5_0001;
  int          resp_waits = 0;
  int          resp_wait_cnt = 0;
  logic        resp_err_once = 1'b0;
  int          n_reads = 0;
  int          n_writes = 0;
  int          n_seed_ready = 0;
  logic [31:0] last_wdata = '0;

  apb4_rng_fetch dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .enable_i     (enable_i),
    .seed_valid_i (seed_valid_i),
    .seed_i       (seed_i),
    .seed_ready_o (seed_ready_o),
    .rnd_valid_o  (rnd_valid_o),
    .rnd_data_o   (rnd_data_o),
    .rnd_ready_i  (rnd_ready_i),
    .err_o        (err_o),
    .paddr_o      (paddr_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .pwdata_o     (pwdata_o),
    .pstrb_o      (pstrb_o),
    .pprot_o      (pprot_o),
    .pready_i     (pready_i),
    .prdata_i     (prdata_i),
    .pslverr_i    (pslverr_i)
  );

  always #5 clk = ~clk;

  // Responder: decides pready for the coming rising edge on each falling edge.
  always @(negedge clk) begin
    if (psel_o && penable_o) begin
      if (resp_wait_cnt < resp_waits) begin
        pready_i      = 1'b0;
        resp_wait_cnt = resp_wait_cnt + 1;
      end else begin
        pready_i      = 1'b1;
        resp_wait_cnt = 0;
        if (pwrite_o) begin
          n_writes   = n_writes + 1;
          last_wdata = pwdata_o;
          pslverr_i  = 1'b0;
        end else begin
          n_reads       = n_reads + 1;
          prdata_i      = resp_val;
          resp_val      = resp_val + 32'd1;
          pslverr_i     = resp_err_once;
          resp_err_once = 1'b0;
        end
      end
    end else begin
      pready_i      = 1'b0;
      pslverr_i     = 1'b0;
      resp_wait_cnt = 0;
    end
    if (seed_ready_o) n_seed_ready = n_seed_ready + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset(input int waits);
    @(negedge clk);
    #1;
    rst_n_i       = 1'b0;
    resp_val      = 32'hA5A5_0001;
    resp_waits    = waits;
    resp_err_once = 1'b0;
    n_reads       = 0;
    n_writes      = 0;
    n_seed_ready  = 0;
    sample();
    sample();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    #1;
    sample();
    n_cmp++; if (psel_o !== 1'b0) begin n_fail++; $display("FAIL rst_psel: got %0h want 0", psel_o); end
    n_cmp++; if (penable_o !== 1'b0) begin n_fail++; $display("FAIL rst_penable: got %0h want 0", penable_o); end
    n_cmp++; if (pwrite_o !== 1'b0) begin n_fail++; $display("FAIL rst_pwrite: got %0h want 0", pwrite_o); end
    n_cmp++; if (paddr_o !== 32'h0) begin n_fail++; $display("FAIL rst_paddr: got %h want 0", paddr_o); end
    n_cmp++; if (pwdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_pwdata: got %h want 0", pwdata_o); end
    n_cmp++; if (pstrb_o !== 4'h0) begin n_fail++; $display("FAIL rst_pstrb: got %h want 0", pstrb_o); end
    n_cmp++; if (pprot_o !== 3'b000) begin n_fail++; $display("FAIL rst_pprot: got %h want 0", pprot_o); end
    n_cmp++; if (seed_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_seed_ready: got %0h want 0", seed_ready_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0h want 0", err_o); end
    n_cmp++; if (rnd_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rnd_valid: got %0h want 0", rnd_valid_o); end
    n_cmp++; if (rnd_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_rnd_data: got %h want 0", rnd_data_o); end
  endtask

  task automatic test_prefetch();
    enable_i = 1'b1;
    apply_reset(0);
    sample();
    n_cmp++; if (psel_o !== 1'b1 || penable_o !== 1'b0) begin n_fail++; $display("FAIL pf_setup: got psel=%0h pen=%0h want 1/0", psel_o, penable_o); end
    n_cmp++; if (paddr_o !== 32'h8 || pwrite_o !== 1'b0) begin n_fail++; $display("FAIL pf_addr: got %h/%0h want 00000008/0", paddr_o, pwrite_o); end
    n_cmp++; if (pstrb_o !== 4'h0 || pwdata_o !== 32'h0) begin n_fail++; $display("FAIL pf_strb: got %h/%h want 0/0", pstrb_o, pwdata_o); end
    sample();
    n_cmp++; if (psel_o !== 1'b1 || penable_o !== 1'b1) begin n_fail++; $display("FAIL pf_access: got psel=%0h pen=%0h want 1/1", psel_o, penable_o); end
    n_cmp++; if (rnd_valid_o !== 1'b0) begin n_fail++; $display("FAIL pf_early_valid: got %0h want 0", rnd_valid_o); end
    sample();
    n_cmp++; if (rnd_valid_o !== 1'b1 || rnd_data_o !== 32'hA5A5_0001) begin n_fail++; $display("FAIL pf_first: got %0h/%h want 1/a5a50001", rnd_valid_o, rnd_data_o); end
    n_cmp++; if (psel_o !== 1'b0) begin n_fail++; $display("FAIL pf_idle_gap: got psel=%0h want 0", psel_o); end
    repeat (20) sample();
    n_cmp++; if (n_reads !== 4) begin n_fail++; $display("FAIL pf_full_reads: got %0d want 4", n_reads); end
    n_cmp++; if (psel_o !== 1'b0) begin n_fail++; $display("FAIL pf_full_idle: got psel=%0h want 0", psel_o); end
    n_cmp++; if (rnd_data_o !== 32'hA5A5_0001) begin n_fail++; $display("FAIL pf_head: got %h want a5a50001", rnd_data_o); end
  endtask

  task automatic test_pop_wrap();
    logic [31:0] exp_word;
    int          popped;
    exp_word    = 32'hA5A5_0001;
    popped      = 0;
    rnd_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (rnd_valid_o && rnd_ready_i) begin
        n_cmp++; if (rnd_data_o !== exp_word) begin n_fail++; $display("FAIL pop_order[%0d]: got %h want %h", popped, rnd_data_o, exp_word); end
        exp_word = exp_word + 32'd1;
        popped   = popped + 1;
      end
      sample();
    end
    rnd_ready_i = 1'b0;
    n_cmp++; if (popped < 12) begin n_fail++; $display("FAIL pop_count: got %0d want >=12", popped); end
  endtask

  task automatic test_seed_priority();
    int waited;
    seed_i       = 32'h1234_5678;
    seed_valid_i = 1'b1;
    enable_i     = 1'b1;
    apply_reset(0);
    sample();
    n_cmp++; if (psel_o !== 1'b1 || paddr_o !== 32'h4 || pwrite_o !== 1'b1) begin n_fail++; $display("FAIL seed_first: got %0h/%h/%0h want 1/00000004/1", psel_o, paddr_o, pwrite_o); end
    n_cmp++; if (pwdata_o !== 32'h1234_5678 || pstrb_o !== 4'hF) begin n_fail++; $display("FAIL seed_data: got %h/%h want 12345678/f", pwdata_o, pstrb_o); end
    sample();
    sample();
    n_cmp++; if (seed_ready_o !== 1'b1 || psel_o !== 1'b0) begin n_fail++; $display("FAIL seed_ready: got %0h/psel=%0h want 1/0", seed_ready_o, psel_o); end
    @(posedge clk);
    #1;
    seed_valid_i = 1'b0;
    sample();
    n_cmp++; if (psel_o !== 1'b1 || paddr_o !== 32'h8 || pwrite_o !== 1'b0) begin n_fail++; $display("FAIL seed_then_read: got %0h/%h/%0h want 1/00000008/0", psel_o, paddr_o, pwrite_o); end
    n_cmp++; if (pstrb_o !== 4'h0 || pwdata_o !== 32'h0 || seed_ready_o !== 1'b0) begin n_fail++; $display("FAIL seed_read_fields: got %h/%h/%0h want 0/0/0", pstrb_o, pwdata_o, seed_ready_o); end
    repeat (15) sample();
    n_cmp++; if (n_seed_ready !== 1 || n_writes !== 1) begin n_fail++; $display("FAIL seed_once: got pulses=%0d writes=%0d want 1/1", n_seed_ready, n_writes); end
    n_cmp++; if (last_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL seed_wdata: got %h want 12345678", last_wdata); end
    // second seed with a full FIFO: prefetched words must survive
    seed_i       = 32'hCAFE_F00D;
    seed_valid_i = 1'b1;
    waited       = 0;
    while (seed_ready_o !== 1'b1 && waited < 20) begin
      sample();
      waited++;
    end
    n_cmp++; if (seed_ready_o !== 1'b1) begin n_fail++; $display("FAIL seed2_timeout: got ready=%0h want 1", seed_ready_o); end
    @(posedge clk);
    #1;
    seed_valid_i = 1'b0;
    sample();
    n_cmp++; if (rnd_valid_o !== 1'b1 || rnd_data_o !== 32'hA5A5_0001) begin n_fail++; $display("FAIL seed_no_flush: got %0h/%h want 1/a5a50001", rnd_valid_o, rnd_data_o); end
    n_cmp++; if (n_seed_ready !== 2 || last_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL seed2: got pulses=%0d wdata=%h want 2/cafef00d", n_seed_ready, last_wdata); end
  endtask

  task automatic test_wait_states();
    enable_i = 1'b1;
    apply_reset(3);
    for (int i = 1; i <= 5; i++) begin
      sample();
      n_cmp++; if (psel_o !== 1'b1 || paddr_o !== 32'h8 || pwrite_o !== 1'b0) begin n_fail++; $display("FAIL ws_stable[%0d]: got %0h/%h/%0h want 1/00000008/0", i, psel_o, paddr_o, pwrite_o); end
      n_cmp++; if (penable_o !== (i >= 2)) begin n_fail++; $display("FAIL ws_penable[%0d]: got %0h want %0h", i, penable_o, (i >= 2)); end
      n_cmp++; if (rnd_valid_o !== 1'b0) begin n_fail++; $display("FAIL ws_early[%0d]: got %0h want 0", i, rnd_valid_o); end
      if (i == 2) enable_i = 1'b0;
    end
    sample();
    n_cmp++; if (rnd_valid_o !== 1'b1 || rnd_data_o !== 32'hA5A5_0001) begin n_fail++; $display("FAIL ws_push: got %0h/%h want 1/a5a50001", rnd_valid_o, rnd_data_o); end
    repeat (6) sample();
    n_cmp++; if (n_reads !== 1 || psel_o !== 1'b0) begin n_fail++; $display("FAIL ws_disabled: got reads=%0d psel=%0h want 1/0", n_reads, psel_o); end
  endtask

  task automatic test_slverr();
    enable_i = 1'b1;
    apply_reset(0);
    resp_err_once = 1'b1;
    repeat (3) sample();
    n_cmp++; if (rnd_valid_o !== 1'b0 || err_o !== 1'b1) begin n_fail++; $display("FAIL err_read: got valid=%0h err=%0h want 0/1", rnd_valid_o, err_o); end
    repeat (3) sample();
    n_cmp++; if (rnd_valid_o !== 1'b1 || rnd_data_o !== 32'hA5A5_0002) begin n_fail++; $display("FAIL err_next: got %0h/%h want 1/a5a50002", rnd_valid_o, rnd_data_o); end
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0h want 1", err_o); end
  endtask

  task automatic test_reset_mid();
    int waited;
    int pulses_before;
    seed_i       = 32'hDEAD_BEEF;
    seed_valid_i = 1'b1;
    waited       = 0;
    while (!(psel_o && penable_o && pwrite_o) && waited < 20) begin
      sample();
      waited++;
    end
    n_cmp++; if (!(psel_o && penable_o && pwrite_o)) begin n_fail++; $display("FAIL rm_timeout: got psel=%0h pen=%0h wr=%0h want 1/1/1", psel_o, penable_o, pwrite_o); end
    pulses_before = n_seed_ready;
    #2;
    rst_n_i = 1'b0;
    #1;
    n_cmp++; if (psel_o !== 1'b0 || penable_o !== 1'b0) begin n_fail++; $display("FAIL rm_async: got psel=%0h pen=%0h want 0/0", psel_o, penable_o); end
    n_cmp++; if (rnd_valid_o !== 1'b0 || rnd_data_o !== 32'h0) begin n_fail++; $display("FAIL rm_fifo: got %0h/%h want 0/0", rnd_valid_o, rnd_data_o); end
    n_cmp++; if (err_o !== 1'b0 || seed_ready_o !== 1'b0) begin n_fail++; $display("FAIL rm_flags: got err=%0h rdy=%0h want 0/0", err_o, seed_ready_o); end
    seed_valid_i = 1'b0;
    enable_i     = 1'b0;
    sample();
    rst_n_i = 1'b1;
    repeat (6) sample();
    n_cmp++; if (n_seed_ready !== pulses_before) begin n_fail++; $display("FAIL rm_no_pulse: got %0d want %0d", n_seed_ready, pulses_before); end
    n_cmp++; if (psel_o !== 1'b0 || rnd_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_quiet: got psel=%0h valid=%0h want 0/0", psel_o, rnd_valid_o); end
  endtask

  initial begin
    test_reset();
    test_prefetch();
    test_pop_wrap();
    test_seed_priority();
    test_wait_states();
    test_slverr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
